alu_issue_queue: RTL and testbench

- Collapsing, age-ordered issue queue that feeds the single-cycle integer ALU.
- Accepts renamed ALU micro-ops from dispatch and holds each one until both source operands are available.
- Operands arrive as values at dispatch, or are captured later from the ALU writeback bus.
- Each cycle it issues the oldest ready op on a registered port that drives the ALU inputs a/b/opc/rob_id/dest/valid.

---
 rtl/alu_issue_queue.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered issue queue for the single-cycle ALU. Entry 0 is the oldest;
// the oldest op whose registered operands are both ready issues on a registered port.
module alu_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_n_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [3:0]       disp_opc_i,
    input  logic [4:0]       disp_rob_id_i,
    input  logic [5:0]       disp_dest_i,
    input  logic [5:0]       disp_src1_tag_i,
    input  logic             disp_src1_rdy_i,
    input  logic [31:0]      disp_src1_data_i,
    input  logic [5:0]       disp_src2_tag_i,
    input  logic             disp_src2_rdy_i,
    input  logic [31:0]      disp_src2_data_i,
    input  logic             wb_valid_i,
    input  logic [5:0]       wb_dest_i,
    input  logic [31:0]      wb_data_i,
    output logic [31:0]      iss_a_o,
    output logic [31:0]      iss_b_o,
    output logic [3:0]       iss_opc_o,
    output logic [4:0]       iss_rob_id_o,
    output logic [5:0]       iss_dest_o,
    output logic             iss_valid_o,
    output logic [CNT_W-1:0] occupancy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [5:0]  tag;
        logic        rdy;
        logic [31:0] data;
    } src_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] opc;
        logic [4:0] rob_id;
        logic [5:0] dest;
        src_t       s1;
        src_t       s2;
    } entry_t;

    // Physical register 0 is hard-wired: never produced, never awaited.
    function automatic src_t wake_src(input src_t s, input logic en,
                                      input logic [5:0] wb_dest, input logic [31:0] wb_data);
        logic hit;
        hit           = en & ~s.rdy & (s.tag == wb_dest) & (wb_dest != 6'd0);
        wake_src      = s;
        wake_src.rdy  = s.rdy | hit;
        wake_src.data = hit ? wb_data : s.data;
    endfunction

    function automatic src_t disp_src(input logic [5:0] tag, input logic rdy, input logic [31:0] data,
                                      input logic wb_v, input logic [5:0] wb_dest,
                                      input logic [31:0] wb_data);
        logic hit;
        hit           = wb_v & (wb_dest == tag) & (tag != 6'd0);
        disp_src.tag  = tag;
        disp_src.rdy  = rdy | (tag == 6'd0) | hit;
        disp_src.data = hit ? wb_data : ((tag == 6'd0) ? 32'd0 : data);
    endfunction

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           wk_s  [DEPTH+1];
    entry_t           new_s;
    logic [CNT_W-1:0] count_q, count_d, wr_cnt_s;
    logic [DEPTH-1:0] rdy_vec_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             sel_found_s, issue_s, disp_fire_s;

    logic             iss_valid_q, iss_valid_d;
    logic [31:0]      iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [3:0]       iss_opc_q, iss_opc_d;
    logic [4:0]       iss_rob_id_q, iss_rob_id_d;
    logic [5:0]       iss_dest_q, iss_dest_d;

    assign disp_ready_o = (count_q < CNT_W'(DEPTH));

    // Oldest-first select over registered readiness only.
    always_comb begin
        sel_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec_s[i] = ent_q[i].valid & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel_idx_s = rdy_vec_s[i] ? IDX_W'(i) : sel_idx_s;
        end
        sel_found_s = |rdy_vec_s;
        issue_s     = sel_found_s & ~flush_i;
        disp_fire_s = disp_valid_i & disp_ready_o & ~flush_i;
    end

    // Queue next state: wakeup, collapse above the issued slot, append dispatch, flush.
    always_comb begin
        new_s        = '0;
        new_s.valid  = 1'b1;
        new_s.opc    = disp_opc_i;
        new_s.rob_id = disp_rob_id_i;
        new_s.dest   = disp_dest_i;
        new_s.s1     = disp_src(disp_src1_tag_i, disp_src1_rdy_i, disp_src1_data_i,
                                wb_valid_i, wb_dest_i, wb_data_i);
        new_s.s2     = disp_src(disp_src2_tag_i, disp_src2_rdy_i, disp_src2_data_i,
                                wb_valid_i, wb_dest_i, wb_data_i);
        wr_cnt_s     = count_q - CNT_W'(issue_s);
        wk_s[DEPTH]  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wk_s[i]    = ent_q[i];
            wk_s[i].s1 = wake_src(ent_q[i].s1, ent_q[i].valid & wb_valid_i, wb_dest_i, wb_data_i);
            wk_s[i].s2 = wake_src(ent_q[i].s2, ent_q[i].valid & wb_valid_i, wb_dest_i, wb_data_i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]       = (issue_s && (IDX_W'(i) >= sel_idx_s)) ? wk_s[i+1] : wk_s[i];
            ent_d[i]       = (disp_fire_s && (wr_cnt_s == CNT_W'(i))) ? new_s : ent_d[i];
            ent_d[i].valid = ent_d[i].valid & ~flush_i;
        end
        count_d = flush_i ? '0 : (count_q + CNT_W'(disp_fire_s) - CNT_W'(issue_s));
    end

    // Issue port next state; payload holds when nothing issues.
    always_comb begin
        iss_valid_d  = issue_s;
        iss_a_d      = issue_s ? ent_q[sel_idx_s].s1.data : iss_a_q;
        iss_b_d      = issue_s ? ent_q[sel_idx_s].s2.data : iss_b_q;
        iss_opc_d    = issue_s ? ent_q[sel_idx_s].opc     : iss_opc_q;
        iss_rob_id_d = issue_s ? ent_q[sel_idx_s].rob_id  : iss_rob_id_q;
        iss_dest_d   = issue_s ? ent_q[sel_idx_s].dest    : iss_dest_q;
    end

    // State registers.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q      <= '0;
            iss_valid_q  <= 1'b0;
            iss_a_q      <= 32'd0;
            iss_b_q      <= 32'd0;
            iss_opc_q    <= 4'd0;
            iss_rob_id_q <= 5'd0;
            iss_dest_q   <= 6'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q      <= count_d;
            iss_valid_q  <= iss_valid_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            iss_opc_q    <= iss_opc_d;
            iss_rob_id_q <= iss_rob_id_d;
            iss_dest_q   <= iss_dest_d;
        end
    end

    assign iss_valid_o  = iss_valid_q;
    assign iss_a_o      = iss_a_q;
    assign iss_b_o      = iss_b_q;
    assign iss_opc_o    = iss_opc_q;
    assign iss_rob_id_o = iss_rob_id_q;
    assign iss_dest_o   = iss_dest_q;
    assign occupancy_o  = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the issue rules.
module tb_alu_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        clk, rst_n, flush;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_opc;
    logic [4:0]  disp_rob;
    logic [5:0]  disp_dest, t1, t2;
    logic        r1, r2;
    logic [31:0] d1, d2;
    logic        wb_valid;
    logic [5:0]  wb_dest;
    logic [31:0] wb_data;
    logic [31:0] iss_a, iss_b;
    logic [3:0]  iss_opc;
    logic [4:0]  iss_rob;
    logic [5:0]  iss_dest;
    logic        iss_valid;
    logic [CNT_W-1:0] occ;

    alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_opc_i(disp_opc), .disp_rob_id_i(disp_rob), .disp_dest_i(disp_dest),
        .disp_src1_tag_i(t1), .disp_src1_rdy_i(r1), .disp_src1_data_i(d1),
        .disp_src2_tag_i(t2), .disp_src2_rdy_i(r2), .disp_src2_data_i(d2),
        .wb_valid_i(wb_valid), .wb_dest_i(wb_dest), .wb_data_i(wb_data),
        .iss_a_o(iss_a), .iss_b_o(iss_b), .iss_opc_o(iss_opc), .iss_rob_id_o(iss_rob),
        .iss_dest_o(iss_dest), .iss_valid_o(iss_valid), .occupancy_o(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic [4:0]  rob;
        logic [5:0]  dest;
        logic [5:0]  t1, t2;
        bit          r1, r2;
        logic [31:0] d1, d2;
    } op_t;

    op_t         mq[$];
    logic        e_valid;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_opc;
    logic [4:0]  e_rob;
    logic [5:0]  e_dest;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; disp_opc = 4'd0; disp_rob = 5'd0; disp_dest = 6'd0;
        t1 = 6'd0; r1 = 1'b0; d1 = 32'd0; t2 = 6'd0; r2 = 1'b0; d2 = 32'd0;
        wb_valid = 1'b0; wb_dest = 6'd0; wb_data = 32'd0;
    endtask

    task automatic disp(input logic [3:0] opc, input logic [4:0] rob, input logic [5:0] dest,
                        input logic [5:0] a_t, input logic a_r, input logic [31:0] a_d,
                        input logic [5:0] b_t, input logic b_r, input logic [31:0] b_d);
        disp_valid = 1'b1; disp_opc = opc; disp_rob = rob; disp_dest = dest;
        t1 = a_t; r1 = a_r; d1 = a_d; t2 = b_t; r2 = b_r; d2 = b_d;
    endtask

    // Dispatch-time operand resolution: same-cycle writeback, then reg 0, then supplied value.
    task automatic resolve(input logic [5:0] tag, input logic rdy, input logic [31:0] data,
                           output bit r_o, output logic [31:0] d_o);
        bit hit;
        hit = wb_valid && (wb_dest == tag) && (tag != 6'd0);
        r_o = rdy || (tag == 6'd0) || hit;
        d_o = hit ? wb_data : ((tag == 6'd0) ? 32'd0 : data);
    endtask

    // One clock of the reference model, evaluated from the pre-edge state.
    task automatic model_edge();
        int  sel;
        op_t n;
        sel = -1;
        if (flush) begin
            mq.delete();
            e_valid = 1'b0;
            return;
        end
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        e_valid = (sel >= 0);
        if (sel >= 0) begin
            e_a = mq[sel].d1; e_b = mq[sel].d2; e_opc = mq[sel].opc;
            e_rob = mq[sel].rob; e_dest = mq[sel].dest;
        end
        if (wb_valid && wb_dest != 6'd0) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == wb_dest) begin mq[i].r1 = 1; mq[i].d1 = wb_data; end
                if (!mq[i].r2 && mq[i].t2 == wb_dest) begin mq[i].r2 = 1; mq[i].d2 = wb_data; end
            end
        end
        if (disp_valid && mq.size() < DEPTH) begin
            n.opc = disp_opc; n.rob = disp_rob; n.dest = disp_dest; n.t1 = t1; n.t2 = t2;
            resolve(t1, r1, d1, n.r1, n.d1);
            resolve(t2, r2, d2, n.r2, n.d2);
        end
        if (sel >= 0) mq.delete(sel);
        if (disp_valid && (mq.size() + ((sel >= 0) ? 1 : 0)) < DEPTH) mq.push_back(n);
    endtask

    task automatic compare_all();
        check("iss_valid", 32'(iss_valid), 32'(e_valid));
        check("iss_a", iss_a, e_a);
        check("iss_b", iss_b, e_b);
        check("iss_opc", 32'(iss_opc), 32'(e_opc));
        check("iss_rob_id", 32'(iss_rob), 32'(e_rob));
        check("iss_dest", 32'(iss_dest), 32'(e_dest));
        check("occupancy", 32'(occ), 32'(mq.size()));
        check("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        mq.delete();
        e_valid = 1'b0; e_a = 32'd0; e_b = 32'd0; e_opc = 4'd0; e_rob = 5'd0; e_dest = 6'd0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Basic ready op: issues two edges after dispatch.
        disp(4'd0, 5'd1, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
        step();
        idle(); step();
        check("t1_valid", 32'(iss_valid), 32'd1);
        check("t1_a", iss_a, 32'd5);
        check("t1_b", iss_b, 32'd7);
        check("t1_occ", 32'(occ), 32'd0);

        // Younger ready op bypasses a blocked older one; wakeup then releases the older.
        disp(4'd2, 5'd10, 6'd11, 6'd1, 1'b1, 32'd1, 6'd9, 1'b0, 32'd0); step();
        disp(4'd3, 5'd11, 6'd12, 6'd1, 1'b1, 32'd2, 6'd2, 1'b1, 32'd3); step();
        idle(); step();
        check("t2_younger_first", 32'(iss_rob), 32'd11);
        wb_valid = 1'b1; wb_dest = 6'd9; wb_data = 32'hDEADBEEF; step();
        idle(); step();
        check("t2_woken_rob", 32'(iss_rob), 32'd10);
        check("t2_woken_b", iss_b, 32'hDEADBEEF);

        // Same-cycle writeback capture at dispatch, and tag 0 reads as zero.
        disp(4'd4, 5'd12, 6'd13, 6'd9, 1'b0, 32'h77, 6'd0, 1'b0, 32'h55);
        wb_valid = 1'b1; wb_dest = 6'd9; wb_data = 32'h1234; step();
        idle(); step();
        check("t3_a", iss_a, 32'h1234);
        check("t3_b", iss_b, 32'd0);

        // Fill with blocked ops, wake the middle one, verify collapse.
        for (int i = 0; i < DEPTH; i++) begin
            disp(4'(i), 5'(i), 6'(20 + i), 6'(10 + i), 1'b0, 32'd0, 6'd1, 1'b1, 32'(i));
            step();
        end
        check("t4_full_ready", 32'(disp_ready), 32'd0);
        check("t4_full_occ", 32'(occ), 32'd8);
        disp(4'd9, 5'd30, 6'd30, 6'd1, 1'b1, 32'd0, 6'd1, 1'b1, 32'd0);
        wb_valid = 1'b1; wb_dest = 6'd15; wb_data = 32'hA5A5; step();
        idle(); step();
        check("t4_issue_rob", 32'(iss_rob), 32'd5);
        check("t4_issue_a", iss_a, 32'hA5A5);
        check("t4_occ", 32'(occ), 32'd7);
        check("t4_ready", 32'(disp_ready), 32'd1);
        wb_valid = 1'b1; wb_dest = 6'd16; wb_data = 32'h66; step();
        idle(); step();
        check("t4_collapsed_rob", 32'(iss_rob), 32'd6);
        flush = 1'b1; step();

        // Flush with a pending issue and a simultaneous dispatch.
        idle();
        for (int i = 0; i < 4; i++) begin
            disp(4'd1, 5'(i), 6'd5, 6'(40 + i), 1'b0, 32'd0, 6'd0, 1'b0, 32'd0); step();
        end
        disp(4'd1, 5'd20, 6'd5, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0); step();
        disp(4'd1, 5'd21, 6'd5, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
        flush = 1'b1; step();
        check("t5_occ", 32'(occ), 32'd0);
        check("t5_valid", 32'(iss_valid), 32'd0);
        idle();
        repeat (3) step();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6) begin
                logic [5:0] ta, tb;
                ta = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
                tb = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 12));
                disp(4'($urandom), 5'($urandom), 6'($urandom_range(0, 12)),
                     ta, 1'($urandom_range(0, 2) == 0), $urandom,
                     tb, 1'($urandom_range(0, 2) == 0), $urandom);
            end
            wb_valid = 1'($urandom_range(0, 1));
            wb_dest  = 6'($urandom_range(0, 12));
            wb_data  = $urandom;
            step();
        end

        // Asynchronous reset while an op is on the issue port.
        idle(); flush = 1'b1; step();
        idle();
        for (int i = 0; i < 3; i++) begin
            disp(4'd5, 5'(i), 6'd7, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0); step();
        end
        check("t6_pre_valid", 32'(iss_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(iss_valid), 32'd0);
        check("t6_async_occ", 32'(occ), 32'd0);
        check("t6_async_a", iss_a, 32'd0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
